// File: rtl/exit_status_ctrl.sv
// APB-controlled test-exit block: software or a watchdog ends the test, the block
// drains for DRAIN_CYCLES so stdout can flush, then raises done with the final status.
module exit_status_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 16,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  paddr,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        done,
    output logic [1:0]  status,
    output logic [30:0] exit_code
);

    localparam int unsigned DW = 8;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_TIMEOUT = 2'd1;
    localparam logic [1:0] REG_EXIT    = 2'd2;
    localparam logic [1:0] REG_STAT    = 2'd3;

    localparam logic [1:0] ST_SUCCESS = 2'b01;
    localparam logic [1:0] ST_FAIL    = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   wdg_en;
    logic [CNT_WIDTH-1:0]   timeout;
    logic [CNT_WIDTH-1:0]   cycle_cnt;
    logic [CNT_WIDTH:0]     cnt_inc;
    logic [DW-1:0]          drain_cnt;
    logic [1:0]             status_q;
    logic [30:0]            code_q;
    logic [31:0]            rdata;
    logic                   unused_addr;

    logic access, wr, ctrl_wr, tmo_wr, start_req, exit_req, timeout_hit;
    logic go_run, go_exit, go_tmo, drain_dec;

    assign unused_addr = ^paddr[1:0];

    // APB decode: an access is the psel&penable phase
    assign access    = psel & penable;
    assign wr        = access & pwrite;
    assign ctrl_wr   = wr && (paddr[3:2] == REG_CTRL);
    assign tmo_wr    = wr && (paddr[3:2] == REG_TIMEOUT);
    assign start_req = ctrl_wr & pwdata[1];
    assign exit_req  = wr && (paddr[3:2] == REG_EXIT) && pwdata[0];

    // Compare one cycle ahead so DRAIN starts on the edge cycle_cnt reaches TIMEOUT
    assign cnt_inc     = {1'b0, cycle_cnt} + (CNT_WIDTH+1)'(1);
    assign timeout_hit = wdg_en && (timeout != '0) && (cnt_inc >= {1'b0, timeout});

    always_comb begin
        state_d   = state_q;
        go_run    = 1'b0;
        go_exit   = 1'b0;
        go_tmo    = 1'b0;
        drain_dec = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_req) begin
                    state_d = RUN;
                    go_run  = 1'b1;
                end
            end
            RUN: begin
                if (exit_req) begin
                    state_d = DRAIN;
                    go_exit = 1'b1;
                end else if (timeout_hit) begin
                    state_d = DRAIN;
                    go_tmo  = 1'b1;
                end
            end
            DRAIN: begin
                if (drain_cnt == DW'(1)) state_d = DONE;
                else                     drain_dec = 1'b1;
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wdg_en    <= 1'b0;
            timeout   <= '0;
            cycle_cnt <= '0;
            drain_cnt <= '0;
            status_q  <= 2'b00;
            code_q    <= '0;
        end else begin
            state_q <= state_d;
            if (ctrl_wr) wdg_en  <= pwdata[0];
            if (tmo_wr)  timeout <= CNT_WIDTH'(pwdata);

            if (go_run)
                cycle_cnt <= '0;
            else if (state_q == RUN && cycle_cnt != '1)
                cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);

            if (go_exit) begin
                code_q    <= pwdata[31:1];
                status_q  <= (pwdata[31:1] == 31'd0) ? ST_SUCCESS : ST_FAIL;
                drain_cnt <= DW'(DRAIN_CYCLES);
            end else if (go_tmo) begin
                code_q    <= '0;
                status_q  <= ST_TIMEOUT;
                drain_cnt <= DW'(DRAIN_CYCLES);
            end else if (drain_dec) begin
                drain_cnt <= drain_cnt - DW'(1);
            end
        end
    end

    // Final result is only visible once the drain has completed
    assign done      = (state_q == DONE);
    assign status    = done ? status_q : 2'b00;
    assign exit_code = done ? code_q : 31'd0;

    always_comb begin
        rdata = '0;
        case (paddr[3:2])
            REG_CTRL:    rdata = 32'(wdg_en);
            REG_TIMEOUT: rdata = 32'(timeout);
            REG_EXIT:    rdata = '0;
            REG_STAT:    rdata = {24'(cycle_cnt), 4'b0000, status, state_q};
            default:     rdata = '0;
        endcase
    end

    assign prdata  = (access && !pwrite) ? rdata : 32'd0;
    assign pslverr = wr && (paddr[3:2] == REG_STAT);
    assign pready  = 1'b1;

endmodule
